regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised successor to the 32×32 MIPS register file: DATA_W × 2^ADDR_W storage with NUM_RD asynchronous read ports, one clocked write port, same-cycle write-to-read bypass, and a per-register pending scoreboard for multi-cycle producers (loads, mult/div). It sits in the decode stage. Hazard control uses the per-port busy flags and the pending count to stall issue.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, address width; depth = 2^ADDR_W (register 0 hard-wired zero)
- NUM_RD, 2, number of read ports (1..4)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port p's register has an outstanding claim
- we  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- claim_en  in  1  mark claim_addr pending (producer issued)
- claim_addr  in  ADDR_W  register claimed
- pend_cnt  out  ADDR_W+1  number of registers currently pending
- claim_err  out  1  registered; claim issued to an already-pending register

## Operation
- Storage: regs[1..2^ADDR_W-1]; address 0 has no storage and always reads 0.
- Read (combinational, per port): addr 0 -> 0. Otherwise, if we && wr_addr==addr, return wr_data (bypass). Otherwise return regs[addr].
- Write: on edge with we && wr_addr!=0, set regs[wr_addr] <= wr_data. Writes to 0 are ignored.
- Scoreboard: busy[2^ADDR_W-1:1] bits. busy[0] is constant 0.
  - claim_en && claim_addr!=0: set busy at edge.
  - we && wr_addr!=0: clear busy at edge. This is the writeback releasing the claim; an unclaimed write is legal and leaves the bit 0.
  - Same edge, same nonzero address, claim and write: busy ends 1 (new claim wins). Data is written.
  - Claim to address 0: ignored. No count change, no error.
- rd_busy[p] = busy[addr] & ~(we && wr_addr==addr). The write in flight is forwarded, so a consumer does not stall on it.
- pend_cnt: popcount of busy, maintained incrementally.
  - Net +1 on a set of a 0 bit.
  - Net -1 on a clear of a 1 bit.
  - Set and clear on different addresses in the same cycle cancel.
  - Never wraps: maximum 2^ADDR_W-1 fits ADDR_W+1 bits.
- claim_err: registered 1 for one cycle after claim_en hits a busy bit that is not cleared the same edge (a WAW claim). busy stays 1 and the count is unchanged.

## Timing
- Reset (rst_n low, asynchronous): all regs = 0, busy = 0, pend_cnt = 0, claim_err = 0. rd_data reads 0 for every address while in reset.
- Reset deasserting mid-operation: state is discarded and the first edge after release behaves as from reset. Claims/writes sampled while rst_n is low are lost.
- Read latency 0 (combinational from rd_addr, we, wr_addr, wr_data).
- Write, claim, and count latency: 1 edge.
- Read-after-write to the same address in the same cycle returns the new data. The next cycle returns it from storage.
- No combinational path from claim_* to any output.

## Structure
- Shared package (regfile_pkg):
  - REG_ZERO = 0 constant.
  - MIPS ABI register-index localparams (ZERO, AT, V0..RA) for benches and decode.
  - Default DATA_W/ADDR_W.
- One sub-module, regfile_scoreboard: owns busy, pend_cnt, claim_err, and the rd_busy masking. The storage, bypass mux, and write logic stay in the top module.

## Test plan
- Reset then read all 32 addresses on both ports -> all rd_data 0, rd_busy 0, pend_cnt 0.
- Write 0xDEADBEEF to addr 8 with rd_addr0=8 in the same cycle -> rd_data0=0xDEADBEEF combinationally, and the next cycle from storage. Write 0x1234 to addr 0 -> reads 0.
- Claim addr 9 -> next cycle rd_busy=1 for any port reading 9, pend_cnt=1. Writeback we/9/0x55 -> rd_busy=0 during that cycle, next cycle busy cleared, pend_cnt=0, read 0x55.
- Same edge claim 10 + write 10 -> busy[10]=1, regs[10]=wr_data, pend_cnt=1. Claim 11 + write to pending 12 in the same edge -> pend_cnt unchanged.
- Claim addr 5 twice across consecutive cycles -> claim_err pulses 1 for one cycle, pend_cnt stays 1. Claim addr 0 -> no change.
- Claim 31 registers, then assert rst_n=0 mid-cycle -> outputs 0 immediately (before next edge), pend_cnt 0. After release, normal operation resumes.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the register file and its scoreboard
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    localparam int unsigned REG_ZERO = 0;

    // MIPS ABI register indices
    localparam logic [4:0] ZERO = 5'd0;
    localparam logic [4:0] AT   = 5'd1;
    localparam logic [4:0] V0   = 5'd2;
    localparam logic [4:0] V1   = 5'd3;
    localparam logic [4:0] A0   = 5'd4;
    localparam logic [4:0] A1   = 5'd5;
    localparam logic [4:0] A2   = 5'd6;
    localparam logic [4:0] A3   = 5'd7;
    localparam logic [4:0] T0   = 5'd8;
    localparam logic [4:0] T1   = 5'd9;
    localparam logic [4:0] T2   = 5'd10;
    localparam logic [4:0] T3   = 5'd11;
    localparam logic [4:0] T4   = 5'd12;
    localparam logic [4:0] T5   = 5'd13;
    localparam logic [4:0] T6   = 5'd14;
    localparam logic [4:0] T7   = 5'd15;
    localparam logic [4:0] S0   = 5'd16;
    localparam logic [4:0] S1   = 5'd17;
    localparam logic [4:0] S2   = 5'd18;
    localparam logic [4:0] S3   = 5'd19;
    localparam logic [4:0] S4   = 5'd20;
    localparam logic [4:0] S5   = 5'd21;
    localparam logic [4:0] S6   = 5'd22;
    localparam logic [4:0] S7   = 5'd23;
    localparam logic [4:0] T8   = 5'd24;
    localparam logic [4:0] T9   = 5'd25;
    localparam logic [4:0] K0   = 5'd26;
    localparam logic [4:0] K1   = 5'd27;
    localparam logic [4:0] GP   = 5'd28;
    localparam logic [4:0] SP   = 5'd29;
    localparam logic [4:0] FP   = 5'd30;
    localparam logic [4:0] RA   = 5'd31;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits, pending count and WAW claim error
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [ADDR_W:0]          pend_cnt,
    output logic                     claim_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             set_v;
    logic             clr_v;
    logic             same;
    logic             inc;
    logic             dec;
    logic             err_nxt;

    always_comb begin
        set_v = claim_en && (claim_addr != ADDR_W'(REG_ZERO));
        clr_v = we && (wr_addr != ADDR_W'(REG_ZERO));
        same  = (claim_addr == wr_addr);
        // a claim landing on the same edge as its writeback wins
        busy_nxt = busy;
        if (clr_v)
            busy_nxt[wr_addr] = 1'b0;
        if (set_v)
            busy_nxt[claim_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
        inc     = set_v && !busy[claim_addr];
        dec     = clr_v && busy[wr_addr] && !(set_v && same);
        err_nxt = set_v && busy[claim_addr] && !(clr_v && same);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= '0;
            pend_cnt  <= '0;
            claim_err <= 1'b0;
        end else begin
            busy      <= busy_nxt;
            pend_cnt  <= pend_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
            claim_err <= err_nxt;
        end
    end

    // the write in flight is forwarded, so it never stalls a reader
    always_comb begin
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++)
            rd_busy[p] = busy[rd_addr[p*ADDR_W +: ADDR_W]]
                       & ~(we && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W]));
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with write bypass and pending scoreboard
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic [ADDR_W:0]          pend_cnt,
    output logic                     claim_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (we && (wr_addr != ADDR_W'(REG_ZERO))) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // bypass is gated by rst_n so every port reads zero while held in reset
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO))
                rd_data[p*DATA_W +: DATA_W] = '0;
            else if (rst_n && we && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W]))
                rd_data[p*DATA_W +: DATA_W] = wr_data;
            else
                rd_data[p*DATA_W +: DATA_W] = regs[rd_addr[p*ADDR_W +: ADDR_W]];
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .wr_addr    (wr_addr),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .pend_cnt   (pend_cnt),
        .claim_err  (claim_err)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - randomized and directed bench for regfile_sb against a behavioural model
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              we;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              claim_en;
    logic [AW-1:0]     claim_addr;
    logic [AW:0]       pend_cnt;
    logic              claim_err;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .pend_cnt   (pend_cnt),
        .claim_err  (claim_err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];
    bit            m_err;
    int            n_chk  = 0;
    int            n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++)
            c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic m_update();
        if (!rst_n) begin
            m_clear();
        end else begin
            m_err = claim_en && claim_addr != 0 && m_busy[claim_addr]
                    && !(we && wr_addr == claim_addr);
            if (we && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (claim_en && claim_addr != 0)
                m_busy[claim_addr] = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [AW-1:0] a;
        logic [DW-1:0] ed;
        logic          eb;
        for (int p = 0; p < NR; p++) begin
            a = rd_addr[p*AW +: AW];
            if (!rst_n || a == 0)            ed = '0;
            else if (we && wr_addr == a)     ed = wr_data;
            else                             ed = m_regs[a];
            eb = rst_n && m_busy[a] && !(we && wr_addr == a);
            chk($sformatf("%s rd_data%0d[a=%0d]", tag, p, a), 64'(rd_data[p*DW +: DW]), 64'(ed));
            chk($sformatf("%s rd_busy%0d[a=%0d]", tag, p, a), 64'(rd_busy[p]), 64'(eb));
        end
        chk({tag, " pend_cnt"}, 64'(pend_cnt), rst_n ? 64'(m_count()) : 64'd0);
        chk({tag, " claim_err"}, 64'(claim_err), rst_n ? 64'(m_err) : 64'd0);
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_outputs(tag);
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic c, input logic [AW-1:0] ca,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        we = w; wr_addr = wa; wr_data = wd;
        claim_en = c; claim_addr = ca;
        rd_addr = {r1, r0};
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0)
            return AW'($urandom_range(0, DEPTH-1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        m_clear();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        step("reset");
        step("reset");
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 0, 0, 0, AW'(i), AW'(DEPTH-1-i));
            step("post_reset");
        end

        drive(1, T0, 32'hDEADBEEF, 0, 0, T0, T0);
        step("bypass");
        drive(0, 0, 0, 0, 0, T0, ZERO);
        step("stored");
        drive(1, ZERO, 32'h1234, 0, 0, ZERO, T0);
        step("write_zero");
        drive(0, 0, 0, 0, 0, ZERO, T0);
        step("read_zero");

        drive(0, 0, 0, 1, T1, T1, T1);
        step("claim9");
        drive(0, 0, 0, 0, 0, T1, T1);
        step("busy9");
        drive(1, T1, 32'h55, 0, 0, T1, T1);
        step("wb9");
        drive(0, 0, 0, 0, 0, T1, T1);
        step("after_wb9");

        drive(1, T2, 32'hA5A5, 1, T2, T2, T2);
        step("claim_wr10");
        drive(0, 0, 0, 0, 0, T2, T2);
        step("after10");
        drive(0, 0, 0, 1, T4, T4, T3);
        step("claim12");
        drive(1, T4, 32'h77, 1, T3, T4, T3);
        step("claim11_wr12");
        drive(0, 0, 0, 0, 0, T4, T3);
        step("after11_12");

        drive(0, 0, 0, 1, A1, A1, A1);
        step("claim5a");
        drive(0, 0, 0, 1, A1, A1, A1);
        step("claim5b");
        drive(0, 0, 0, 0, 0, A1, A1);
        step("err_pulse");
        step("err_gone");
        drive(0, 0, 0, 1, ZERO, ZERO, A1);
        step("claim0");
        drive(0, 0, 0, 0, 0, ZERO, A1);
        step("after_claim0");

        for (int i = 1; i < DEPTH; i++) begin
            drive(0, 0, 0, 1, AW'(i), AW'(i), AW'(DEPTH-i));
            step("claim_all");
        end
        drive(0, 0, 0, 0, 0, RA, SP);
        step("all_pending");

        #2;
        drive(1, A3, 32'hCAFE, 1, V1, A3, V1);
        rst_n = 1'b0;
        m_clear();
        #1;
        check_outputs("async_rst");
        step("in_rst");
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, A3, V1);
        step("released");
        drive(1, A3, 32'h9, 1, V1, A3, V1);
        step("resume");
        drive(0, 0, 0, 0, 0, A3, V1);
        step("resume_rd");

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0)
                rst_n = 1'b0;
            else
                rst_n = 1'b1;
            drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
                  1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), rnd_addr());
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
